// File: rtl/hex_entry_if.sv
// hex_entry_if: keypad pulses in, entry state and committed-value stream out
interface hex_entry_if;
    logic [15:0] key;
    logic        ent;
    logic        del;
    logic [31:0] value;
    logic [3:0]  count;
    logic [7:0]  disp_mask;
    logic        ovf;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (
        output key, ent, del, out_ready,
        input  value, count, disp_mask, ovf, out_data, out_valid
    );
    modport slave (
        input  key, ent, del, out_ready,
        output value, count, disp_mask, ovf, out_data, out_valid
    );
endinterface

// File: rtl/hex_entry.sv
// hex_entry: hex keypad entry buffer with backspace, overflow flag and a valid/ready commit port
module hex_entry #(
    parameter int MAX_DIGITS = 8
) (
    input logic       clk,
    input logic       rst,
    hex_entry_if.slave bus
);
    localparam logic [3:0] MAX = 4'(MAX_DIGITS);
    logic [31:0] r_value;
    logic [31:0] r_out_data;
    logic [3:0]  r_count;
    logic        r_ovf;
    logic        r_out_valid;
    logic [3:0]  w_digit;
    logic        w_key;
    logic        w_xfer;
    logic        w_commit;
    logic        w_del;
    logic        w_push;
    logic        w_drop;
    // descending scan leaves the lowest set key bit as the digit
    always_comb begin
        w_digit = '0;
        for (int i = 15; i >= 0; i--) w_digit = bus.key[i] ? 4'(i) : w_digit;
    end
    assign w_key    = |bus.key;
    assign w_xfer   = r_out_valid & bus.out_ready;
    assign w_commit = bus.ent & (r_count != 0) & (~r_out_valid | bus.out_ready);
    assign w_del    = ~bus.ent & bus.del & (r_count != 0);
    assign w_push   = ~bus.ent & ~bus.del & w_key & (r_count < MAX);
    assign w_drop   = ~bus.ent & ~bus.del & w_key & (r_count == MAX);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_commit) begin
            r_out_data  <= r_value;
            r_out_valid <= 1'b1;
            r_value     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_xfer) r_out_valid <= 1'b0;
            if (w_del) begin
                r_value <= r_value >> 4;
                r_count <= r_count - 4'd1;
                r_ovf   <= 1'b0;
            end
            if (w_push) begin
                r_value <= {r_value[27:0], w_digit};
                r_count <= r_count + 4'd1;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end
    assign bus.value     = r_value;
    assign bus.count     = r_count;
    assign bus.disp_mask = ~(8'hFF << r_count);
    assign bus.ovf       = r_ovf;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: directed scenarios plus random traffic checked against a digit-queue model
module tb_hex_entry;
    localparam int MAXD = 8;
    logic clk = 1'b0;
    logic rst;
    hex_entry_if bus ();
    hex_entry #(.MAX_DIGITS(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_pass = 0;
    int m_q[$];
    logic m_ovf = 1'b0;
    logic m_valid = 1'b0;
    logic [31:0] m_data = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [31:0] m_value();
        logic [31:0] v = '0;
        foreach (m_q[i]) v = v * 16 + 32'(m_q[i]);
        return v;
    endfunction
    function automatic int lowest(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction
    task automatic compare_all(input string tag);
        check({tag, ".value"}, bus.value, m_value());
        check({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
        check({tag, ".mask"}, 32'(bus.disp_mask), 32'((1 << m_q.size()) - 1));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".data"}, bus.out_data, m_data);
    endtask
    task automatic step(input logic [15:0] k, input logic e, input logic d, input logic r, input logic rs, input string tag);
        logic xfer;
        bus.key = k; bus.ent = e; bus.del = d; bus.out_ready = r; rst = rs;
        @(posedge clk);
        xfer = m_valid & r;
        if (rs) begin
            m_q.delete(); m_ovf = 0; m_valid = 0; m_data = '0;
        end else if (e && m_q.size() > 0 && (!m_valid || r)) begin
            m_data = m_value(); m_valid = 1; m_q.delete(); m_ovf = 0;
        end else begin
            if (xfer) m_valid = 0;
            if (!e && d) begin
                if (m_q.size() > 0) begin void'(m_q.pop_back()); m_ovf = 0; end
            end else if (!e && k != 0) begin
                if (m_q.size() < MAXD) m_q.push_back(lowest(k));
                else m_ovf = 1;
            end
        end
        #1;
        compare_all(tag);
    endtask
    initial begin
        logic [15:0] k;
        step(16'h0, 0, 0, 0, 1, "rst");
        check("rst_value", bus.value, 32'h0);
        check("rst_mask", 32'(bus.disp_mask), 32'h0);
        // keys 1, A, 3 then commit
        step(16'h0002, 0, 0, 1, 0, "r30_k1");
        check("r30_cnt1", 32'(bus.count), 32'd1);
        step(16'h0400, 0, 0, 1, 0, "r30_kA");
        step(16'h0008, 0, 0, 1, 0, "r30_k3");
        check("r30_value", bus.value, 32'h1A3);
        step(16'h0, 1, 0, 1, 0, "r30_ent");
        check("r30_data", bus.out_data, 32'h1A3);
        check("r30_valid", 32'(bus.out_valid), 32'd1);
        step(16'h0, 0, 0, 1, 0, "r30_idle");
        check("r30_drop", 32'(bus.out_valid), 32'd0);
        // fill, overflow, backspace
        for (int i = 0; i < 8; i++) step(16'h8000, 0, 0, 1, 0, "r31_fill");
        step(16'h0020, 0, 0, 1, 0, "r31_k5");
        check("r31_value", bus.value, 32'hFFFFFFFF);
        check("r31_ovf", 32'(bus.ovf), 32'd1);
        step(16'h0, 0, 1, 1, 0, "r31_del");
        check("r31_delv", bus.value, 32'h0FFFFFFF);
        check("r31_delc", 32'(bus.count), 32'd7);
        step(16'h0, 1, 0, 1, 0, "r31_ent");
        step(16'h0, 0, 0, 1, 0, "r31_idle");
        // multi-bit key, then ent beats key
        step(16'h0028, 0, 0, 1, 0, "r32_key");
        check("r32_value", bus.value, 32'h3);
        step(16'h0002, 0, 0, 1, 0, "r33_k1");
        step(16'h0080, 1, 0, 1, 0, "r33_entk");
        check("r33_data", bus.out_data, 32'h31);
        check("r33_count", 32'(bus.count), 32'd0);
        step(16'h0, 0, 0, 1, 0, "r33_idle");
        // backpressure on commit
        step(16'h0002, 0, 0, 0, 0, "r34_k1");
        step(16'h0004, 0, 0, 0, 0, "r34_k2");
        step(16'h0, 1, 0, 0, 0, "r34_ent1");
        step(16'h0008, 0, 0, 0, 0, "r34_k3");
        step(16'h0010, 0, 0, 0, 0, "r34_k4");
        step(16'h0, 1, 0, 0, 0, "r34_blk");
        check("r34_hold", bus.out_data, 32'h12);
        check("r34_cnt", 32'(bus.count), 32'd2);
        step(16'h0, 1, 0, 1, 0, "r34_ent2");
        check("r34_data", bus.out_data, 32'h34);
        check("r34_valid", 32'(bus.out_valid), 32'd1);
        step(16'h0, 0, 0, 1, 0, "r34_idle");
        // reset mid-entry with pending output
        step(16'h0002, 0, 0, 0, 0, "r35_k");
        step(16'h0, 1, 0, 0, 0, "r35_ent");
        for (int i = 0; i < 5; i++) step(16'h0200, 0, 0, 0, 0, "r35_fill");
        check("r35_pre", 32'(bus.count), 32'd5);
        step(16'h0040, 1, 1, 1, 1, "r35_rst");
        check("r35_valid", 32'(bus.out_valid), 32'd0);
        check("r35_value", bus.value, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            k = ($urandom_range(0, 1) == 0) ? 16'h0
              : ($urandom_range(0, 1) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            step(k, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) < 3, $urandom_range(0, 199) == 0, "rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
